// File: rtl/sprite_compositor.sv
// sprite_compositor: N-channel sprite mixer placed between the VGA timing
// generator and the pixel output register.
// Sprite registers are double-buffered and only take effect at frame start.
// Each pixel travels through three stages:
//   - stage 1 produces the ROM addresses and the hit mask,
//   - stage 2 waits for ROM data to return,
//   - stage 3 registers the composited pixel.
// Optional feature macro: COMPOSITOR_FLIP_EN adds per-sprite horizontal mirroring.
module sprite_compositor #(
    parameter int          NUM_SPRITES = 8,
    parameter int          ADDR_W      = 14,
    parameter logic [11:0] KEY_COLOR   = 12'h428
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            frame_start,
    input  logic                            pix_valid,
    input  logic [9:0]                      col,
    input  logic [8:0]                      row,
    input  logic                            wr_en,
    input  logic [$clog2(NUM_SPRITES)-1:0]  wr_idx,
    input  logic [9:0]                      wr_x,
    input  logic [8:0]                      wr_y,
    input  logic [6:0]                      wr_w,
    input  logic [6:0]                      wr_h,
    input  logic [ADDR_W-1:0]               wr_base,
    input  logic                            wr_enable,
    input  logic                            wr_flip,
    output logic [NUM_SPRITES*ADDR_W-1:0]   spr_addr,
    input  logic [NUM_SPRITES*12-1:0]       spr_data,
    input  logic [11:0]                     bg_data,
    output logic [11:0]                     pix_out,
    output logic                            pix_out_valid,
    output logic [NUM_SPRITES-1:0]          coll_flags
);

    localparam int IDX_W = $clog2(NUM_SPRITES);

    // Pending (software-written) and active (drawing) register sets
    logic [9:0]        r_pend_x    [NUM_SPRITES];
    logic [8:0]        r_pend_y    [NUM_SPRITES];
    logic [6:0]        r_pend_w    [NUM_SPRITES];
    logic [6:0]        r_pend_h    [NUM_SPRITES];
    logic [ADDR_W-1:0] r_pend_base [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_pend_en;
    logic [9:0]        r_act_x     [NUM_SPRITES];
    logic [8:0]        r_act_y     [NUM_SPRITES];
    logic [6:0]        r_act_w     [NUM_SPRITES];
    logic [6:0]        r_act_h     [NUM_SPRITES];
    logic [ADDR_W-1:0] r_act_base  [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_act_en;
`ifdef COMPOSITOR_FLIP_EN
    logic [NUM_SPRITES-1:0] r_pend_flip;
    logic [NUM_SPRITES-1:0] r_act_flip;
`else
    logic w_unused_flip;
    assign w_unused_flip = wr_flip;
`endif

    // Pipeline state
    logic [NUM_SPRITES-1:0] r_hit1, r_hit2, r_coll_acc;
    logic                   r_v1, r_v2;

    // Stage-0 combinational hit/address terms
    logic [10:0]       w_x_end  [NUM_SPRITES];
    logic [9:0]        w_y_end  [NUM_SPRITES];
    logic [9:0]        w_dx     [NUM_SPRITES];
    logic [8:0]        w_dy     [NUM_SPRITES];
    logic [9:0]        w_dx_eff [NUM_SPRITES];
    logic [ADDR_W-1:0] w_addr   [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] w_hit;
    logic                   w_wr_ok;

    // Stage-2 combinational mix/collision terms
    logic [NUM_SPRITES-1:0] w_opq;
    logic [NUM_SPRITES-1:0] w_coll;
    logic [11:0]            w_mix;
    logic                   w_seen, w_many;

    // An index beyond the sprite count is dropped (only possible for non-power-of-two counts)
    assign w_wr_ok = wr_en && ({1'b0, wr_idx} < (IDX_W+1)'(NUM_SPRITES));

    // Capture register writes into the pending set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_pend_x[i]    <= 10'd0;
                r_pend_y[i]    <= 9'd0;
                r_pend_w[i]    <= 7'd0;
                r_pend_h[i]    <= 7'd0;
                r_pend_base[i] <= '0;
            end
            r_pend_en <= '0;
`ifdef COMPOSITOR_FLIP_EN
            r_pend_flip <= '0;
`endif
        end else if (w_wr_ok) begin
            r_pend_x[wr_idx]    <= wr_x;
            r_pend_y[wr_idx]    <= wr_y;
            r_pend_w[wr_idx]    <= wr_w;
            r_pend_h[wr_idx]    <= wr_h;
            r_pend_base[wr_idx] <= wr_base;
            r_pend_en[wr_idx]   <= wr_enable;
`ifdef COMPOSITOR_FLIP_EN
            r_pend_flip[wr_idx] <= wr_flip;
`endif
        end
    end

    // Promote pending to active at frame start, letting a same-cycle write through directly
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_act_x[i]    <= 10'd0;
                r_act_y[i]    <= 9'd0;
                r_act_w[i]    <= 7'd0;
                r_act_h[i]    <= 7'd0;
                r_act_base[i] <= '0;
            end
            r_act_en <= '0;
`ifdef COMPOSITOR_FLIP_EN
            r_act_flip <= '0;
`endif
        end else if (frame_start) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (w_wr_ok && (wr_idx == IDX_W'(i))) begin
                    r_act_x[i]    <= wr_x;
                    r_act_y[i]    <= wr_y;
                    r_act_w[i]    <= wr_w;
                    r_act_h[i]    <= wr_h;
                    r_act_base[i] <= wr_base;
                    r_act_en[i]   <= wr_enable;
`ifdef COMPOSITOR_FLIP_EN
                    r_act_flip[i] <= wr_flip;
`endif
                end else begin
                    r_act_x[i]    <= r_pend_x[i];
                    r_act_y[i]    <= r_pend_y[i];
                    r_act_w[i]    <= r_pend_w[i];
                    r_act_h[i]    <= r_pend_h[i];
                    r_act_base[i] <= r_pend_base[i];
                    r_act_en[i]   <= r_pend_en[i];
`ifdef COMPOSITOR_FLIP_EN
                    r_act_flip[i] <= r_pend_flip[i];
`endif
                end
            end
        end
    end

    // Hit test and ROM address per sprite; widened end coordinates clip instead of wrapping
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_x_end[i] = {1'b0, r_act_x[i]} + {4'b0, r_act_w[i]};
            w_y_end[i] = {1'b0, r_act_y[i]} + {3'b0, r_act_h[i]};
            w_dx[i]    = col - r_act_x[i];
            w_dy[i]    = row - r_act_y[i];
`ifdef COMPOSITOR_FLIP_EN
            w_dx_eff[i] = r_act_flip[i] ? ({3'b0, r_act_w[i]} - 10'd1 - w_dx[i]) : w_dx[i];
`else
            w_dx_eff[i] = w_dx[i];
`endif
            w_hit[i] = r_act_en[i] && pix_valid &&
                       (col >= r_act_x[i]) && ({1'b0, col} < w_x_end[i]) &&
                       (row >= r_act_y[i]) && ({1'b0, row} < w_y_end[i]);
            w_addr[i] = w_hit[i] ? (ADDR_W'(w_dy[i]) * ADDR_W'(r_act_w[i]) +
                                    ADDR_W'(w_dx_eff[i]) + r_act_base[i])
                                 : '0;
        end
    end

    // Stages 1 and 2: register addresses and hit mask, then align hits with returning ROM data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spr_addr <= '0;
            r_hit1   <= '0;
            r_hit2   <= '0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                spr_addr[i*ADDR_W +: ADDR_W] <= w_addr[i];
            end
            r_hit1 <= w_hit;
            r_v1   <= pix_valid;
            r_hit2 <= r_hit1;
            r_v2   <= r_v1;
        end
    end

    // Opacity, fixed-priority mix (higher index wins) and multi-sprite overlap detection
    always_comb begin
        w_mix  = bg_data;
        w_seen = 1'b0;
        w_many = 1'b0;
        w_opq  = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_opq[i] = r_hit2[i] && (spr_data[i*12 +: 12] != KEY_COLOR);
            w_mix    = w_opq[i] ? spr_data[i*12 +: 12] : w_mix;
            w_many   = w_many | (w_seen & w_opq[i]);
            w_seen   = w_seen | w_opq[i];
        end
        w_coll = w_many ? w_opq : '0;
    end

    // Stage 3: register the output pixel, blanked when the source pixel was not visible
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_out       <= 12'd0;
            pix_out_valid <= 1'b0;
        end else begin
            pix_out       <= r_v2 ? w_mix : 12'd0;
            pix_out_valid <= r_v2;
        end
    end

    // Accumulate overlaps over a frame and publish them at frame start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_coll_acc <= '0;
            coll_flags <= '0;
        end else if (frame_start) begin
            coll_flags <= r_coll_acc | w_coll;
            r_coll_acc <= '0;
        end else begin
            r_coll_acc <= r_coll_acc | w_coll;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed, table-driven bench for sprite_compositor (default 8 sprites, 14-bit addresses).
module tb_sprite_compositor;

    localparam int          N  = 8;
    localparam int          AW = 14;
    localparam logic [11:0] K  = 12'h428;
    localparam logic [11:0] A  = 12'hABC;

    logic              clk, rstn, frame_start, pix_valid;
    logic [9:0]        col;
    logic [8:0]        row;
    logic              wr_en, wr_enable, wr_flip;
    logic [2:0]        wr_idx;
    logic [9:0]        wr_x;
    logic [8:0]        wr_y;
    logic [6:0]        wr_w, wr_h;
    logic [AW-1:0]     wr_base;
    logic [N*AW-1:0]   spr_addr;
    logic [N*12-1:0]   spr_data;
    logic [11:0]       bg_data, pix_out;
    logic              pix_out_valid;
    logic [N-1:0]      coll_flags;

    sprite_compositor #(.NUM_SPRITES(N), .ADDR_W(AW), .KEY_COLOR(K)) dut (
        .clk(clk), .rstn(rstn), .frame_start(frame_start), .pix_valid(pix_valid),
        .col(col), .row(row), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_w(wr_w), .wr_h(wr_h), .wr_base(wr_base), .wr_enable(wr_enable),
        .wr_flip(wr_flip), .spr_addr(spr_addr), .spr_data(spr_data), .bg_data(bg_data),
        .pix_out(pix_out), .pix_out_valid(pix_out_valid), .coll_flags(coll_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [9:0]  c;
        logic [8:0]  r;
        logic        v;
        logic [95:0] sdat;
        logic [11:0] bg;
        int          si;
        logic [13:0] ea;
        logic [11:0] ep;
        logic        epv;
    } vec_t;

    vec_t tv[14];
    int   n_vec = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] sd(input logic [11:0] d0, d1, d2, d3, d4, d5, d6, d7);
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic add(input string name, input int c, input int r, input logic v,
                       input logic [95:0] sdat, input logic [11:0] bg, input int si,
                       input int ea, input logic [11:0] ep, input logic epv);
        tv[n_vec].name = name;  tv[n_vec].c  = 10'(c); tv[n_vec].r  = 9'(r);
        tv[n_vec].v    = v;     tv[n_vec].sdat = sdat; tv[n_vec].bg = bg;
        tv[n_vec].si   = si;    tv[n_vec].ea = 14'(ea); tv[n_vec].ep = ep;
        tv[n_vec].epv  = epv;
        n_vec++;
    endtask

    task automatic wr_sprite(input int idx, input int x, input int y, input int w, input int h,
                             input int base, input logic en, input logic flip, input logic fs);
        wr_idx = 3'(idx); wr_x = 10'(x); wr_y = 9'(y); wr_w = 7'(w); wr_h = 7'(h);
        wr_base = AW'(base); wr_enable = en; wr_flip = flip;
        wr_en = 1'b1; frame_start = fs;
        @(posedge clk); #1;
        wr_en = 1'b0; frame_start = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // Present one pixel; address sampled one edge later, composited pixel three edges later
    task automatic run_pixel(input logic [9:0] c, input logic [8:0] r, input logic v,
                             input logic [95:0] sdat, input logic [11:0] bg,
                             output logic [N*AW-1:0] a, output logic [11:0] p, output logic pv);
        col = c; row = r; pix_valid = v; spr_data = sdat; bg_data = bg;
        @(posedge clk); #1;
        a = spr_addr;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        p  = pix_out;
        pv = pix_out_valid;
    endtask

    logic [N*AW-1:0] ga;
    logic [11:0]     gp;
    logic            gpv;

    initial begin
        rstn = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; col = 10'd0; row = 9'd0;
        wr_en = 1'b0; wr_idx = 3'd0; wr_x = 10'd0; wr_y = 9'd0; wr_w = 7'd0; wr_h = 7'd0;
        wr_base = '0; wr_enable = 1'b0; wr_flip = 1'b0;
        spr_data = '0; bg_data = 12'd0;

        // Vector table (sprite layout configured below)
        add("addr_s0",        110,  52, 1'b1, sd(A,K,K,K,K,K,K,K),                12'h111, 0,  304, A,       1'b1);
        add("s0_origin",      100,  50, 1'b1, sd(A,K,K,K,K,K,K,K),                12'h111, 0,  200, A,       1'b1);
        add("s0_last_px",     146,  90, 1'b1, sd(A,K,K,K,K,K,K,K),                12'h111, 0, 2126, A,       1'b1);
        add("s0_right_out",   147,  50, 1'b1, sd(A,K,K,K,K,K,K,K),                12'h111, 0,    0, 12'h111, 1'b1);
        add("s0_bottom_out",  100,  91, 1'b1, sd(A,K,K,K,K,K,K,K),                12'h111, 0,    0, 12'h111, 1'b1);
        add("s0_left_out",     99,  60, 1'b1, sd(A,K,K,K,K,K,K,K),                12'h111, 0,    0, 12'h111, 1'b1);
        add("prio_3_over_1",  310, 110, 1'b1, sd(K,12'hF00,K,12'h0F0,K,K,K,K),    12'h222, 3, 2105, 12'h0F0, 1'b1);
        add("key_on_3",       310, 110, 1'b1, sd(K,12'hF00,K,K,K,K,K,K),         12'h222, 1, 1210, 12'hF00, 1'b1);
        add("key_on_both",    310, 110, 1'b1, sd(K,K,K,K,K,K,K,K),                12'h222, 1, 1210, 12'h222, 1'b1);
        add("only_1_hit",     301, 101, 1'b1, sd(K,12'hF00,K,12'h0F0,K,K,K,K),    12'h222, 3,    0, 12'hF00, 1'b1);
        add("clip_hit",      1020,  12, 1'b1, sd(K,K,K,K,12'h0AA,K,K,K),         12'h333, 4, 3114, 12'h0AA, 1'b1);
        add("clip_no_wrap",     5,  12, 1'b1, sd(K,K,K,K,12'h0AA,K,K,K),         12'h333, 4,    0, 12'h333, 1'b1);
        add("zero_width",     400, 205, 1'b1, sd(K,K,K,K,K,K,12'h555,K),         12'h333, 6,    0, 12'h333, 1'b1);
        add("invalid_px",     110,  52, 1'b0, sd(A,K,K,K,K,K,K,K),                12'h111, 0,    0, 12'h000, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_out",   32'(pix_out), 32'd0);
        check("rst_pix_valid", 32'(pix_out_valid), 32'd0);
        check("rst_coll",      32'(coll_flags), 32'd0);
        check("rst_addr_nz",   32'(spr_addr != '0), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Double buffer: pending write must not draw before frame start
        wr_sprite(0, 100, 50, 47, 41, 0, 1'b1, 1'b0, 1'b0);
        run_pixel(10'd100, 9'd50, 1'b1, sd(A,K,K,K,K,K,K,K), 12'h111, ga, gp, gpv);
        check("dbuf_pre_addr", 32'(ga[0 +: AW]), 32'd0);
        check("dbuf_pre_pix",  32'(gp), 32'h111);
        pulse_fs();
        run_pixel(10'd100, 9'd50, 1'b1, sd(A,K,K,K,K,K,K,K), 12'h111, ga, gp, gpv);
        check("dbuf_post_addr", 32'(ga[0 +: AW]), 32'd0);
        check("dbuf_post_pix",  32'(gp), 32'(A));

        // Layout; the sprite 0 rewrite coincides with frame start and must apply at once
        wr_sprite(1,  300, 100, 20, 20, 1000, 1'b1, 1'b0, 1'b0);
        wr_sprite(2,  500, 300, 10, 10,  100, 1'b1, 1'b0, 1'b0);
        wr_sprite(3,  305, 105, 20, 20, 2000, 1'b1, 1'b0, 1'b0);
        wr_sprite(4, 1000,  10, 47, 10, 3000, 1'b1, 1'b0, 1'b0);
        wr_sprite(5,  505, 305, 10, 10,  500, 1'b1, 1'b0, 1'b0);
        wr_sprite(6,  400, 200,  0, 10,    0, 1'b1, 1'b0, 1'b0);
        wr_sprite(0,  100,  50, 47, 41,  200, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < n_vec; i++) begin
            run_pixel(tv[i].c, tv[i].r, tv[i].v, tv[i].sdat, tv[i].bg, ga, gp, gpv);
            check({tv[i].name, "_addr"},  32'(ga[tv[i].si*AW +: AW]), 32'(tv[i].ea));
            check({tv[i].name, "_pix"},   32'(gp),  32'(tv[i].ep));
            check({tv[i].name, "_valid"}, 32'(gpv), 32'(tv[i].epv));
        end

        // Sprites 1 and 3 overlapped opaquely in prio_3_over_1
        pulse_fs();
        check("coll_table_frame", 32'(coll_flags), 32'h0A);

        // Collision between sprites 2 and 5, then an overlap-free frame
        run_pixel(10'd507, 9'd307, 1'b1, sd(K,K,12'h123,K,K,12'h456,K,K), 12'h111, ga, gp, gpv);
        check("coll_px_addr5", 32'(ga[5*AW +: AW]), 32'd522);
        check("coll_px_pix",   32'(gp), 32'h456);
        pulse_fs();
        check("coll_frame_k",  32'(coll_flags), 32'h24);
        pulse_fs();
        check("coll_frame_k1", 32'(coll_flags), 32'h00);
        run_pixel(10'd507, 9'd307, 1'b1, sd(K,K,12'h123,K,K,12'h456,K,K), 12'h111, ga, gp, gpv);
        pulse_fs();
        check("coll_again", 32'(coll_flags), 32'h24);

        // Asynchronous reset mid-line with sprites active
        col = 10'd110; row = 9'd52; pix_valid = 1'b1;
        spr_data = sd(A,K,K,K,K,K,K,K); bg_data = 12'h111;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(pix_out_valid), 32'd1);
        check("pre_rst_addr0", 32'(spr_addr[0 +: AW]), 32'd304);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_pix",   32'(pix_out), 32'd0);
        check("mid_rst_valid", 32'(pix_out_valid), 32'd0);
        check("mid_rst_addr",  32'(spr_addr != '0), 32'd0);
        check("mid_rst_coll",  32'(coll_flags), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1; pix_valid = 1'b0;
        @(posedge clk); #1;
        pulse_fs();
        run_pixel(10'd110, 9'd52, 1'b1, sd(A,K,K,K,K,K,K,K), 12'h111, ga, gp, gpv);
        check("post_rst_addr", 32'(ga[0 +: AW]), 32'd0);
        check("post_rst_pix",  32'(gp), 32'h111);

        // Horizontal flip request: mirrored only when the feature is built in
        wr_sprite(0, 100, 50, 47, 41, 200, 1'b1, 1'b1, 1'b1);
        run_pixel(10'd110, 9'd52, 1'b1, sd(A,K,K,K,K,K,K,K), 12'h111, ga, gp, gpv);
`ifdef COMPOSITOR_FLIP_EN
        check("flip_addr", 32'(ga[0 +: AW]), 32'd330);
`else
        check("flip_addr", 32'(ga[0 +: AW]), 32'd304);
`endif
        check("flip_pix", 32'(gp), 32'(A));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-channel sprite layer mixer between the VGA timing generator and the pixel output register. Per-sprite position, size, ROM base and enable are loaded through a register write port and double-buffered so they apply only at frame start. The block generates sprite ROM addresses, merges returned sprite pixels over a background pixel by fixed priority with a transparency key, and reports per-frame sprite-to-sprite overlap flags.

## Interface
- NUM_SPRITES, 8: sprite channels; higher index has higher priority.
- ADDR_W, 14: sprite ROM address width.
- KEY_COLOR, 12'h428: transparent RGB444 value.
- clk  in  1  pixel-pipeline clock.
- rstn  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pix_valid  in  1  col/row qualify a visible pixel.
- col  in  10  pixel x.
- row  in  9  pixel y.
- wr_en  in  1  register write strobe.
- wr_idx  in  $clog2(NUM_SPRITES)  target sprite.
- wr_x / wr_y  in  10 / 9  top-left position.
- wr_w / wr_h  in  7 / 7  size in pixels (0 = never drawn).
- wr_base  in  ADDR_W  ROM base address of the image.
- wr_enable  in  1  sprite visible.
- wr_flip  in  1  horizontal mirror (used only with COMPOSITOR_FLIP_EN).
- spr_addr  out  NUM_SPRITES*ADDR_W  per-sprite ROM address, sprite i at [i*ADDR_W +: ADDR_W].
- spr_data  in  NUM_SPRITES*12  ROM data, one cycle after spr_addr.
- bg_data  in  12  background pixel, aligned with spr_data.
- pix_out  out  12  composited pixel.
- pix_out_valid  out  1  pix_out qualifier.
- coll_flags  out  NUM_SPRITES  overlap flags of the previous frame.

## Operation
- Two register sets per sprite: pending (written by wr_en) and active (used for drawing). An out-of-range wr_idx is ignored.
- On frame_start: active <= pending. A write in the same cycle as frame_start is merged, so the written value becomes active immediately.
- Hit test per sprite, with widened arithmetic (11/10 bit, no wrap): hit = enable && col>=x && col<x+w && row>=y && row<y+h && pix_valid. A sprite extending past col 1023 or row 511 is clipped.
- Address: dx = col-x, dy = row-y, addr = base + dy*w + dx, modulo 2^ADDR_W. With flip: dx' = w-1-dx. A non-hit sprite drives addr 0.
- Opaque: hit delayed to the data stage and spr_data_i != KEY_COLOR.
- Mix: pix_out = spr_data of the highest-index opaque sprite, else bg_data. pix_out is 0 when the qualifying pix_valid was 0.
- Collision: when two or more sprites are opaque on the same pixel, their bits are OR-ed into an accumulator. On frame_start: coll_flags <= accumulator (including any overlap in that same cycle), then the accumulator clears.

## Timing
- Three-stage pipeline.
  - Cycle N: pix_valid/col/row are sampled.
  - N+1: spr_addr and the internal hit register update.
  - N+2: the bench or ROM presents spr_data and bg_data.
  - N+3: pix_out and pix_out_valid are registered.
- Latency is 3 cycles. Throughput is one pixel per clock, with no stalls.
- Pixels already in flight at frame_start complete with the registers they sampled at stage 1.
- Reset, asynchronous on rstn low: all pending/active registers 0 (all sprites disabled), spr_addr 0, pix_out 0, pix_out_valid 0, coll_flags 0, accumulator 0.
- Reset deasserted mid-frame: output shows background only until the first writes have been applied by a frame_start.

## Configuration
- COMPOSITOR_FLIP_EN defined: a flip bit is stored per sprite and mirrored addressing applies.
- COMPOSITOR_FLIP_EN undefined: wr_flip is ignored, no flip storage or mirror logic is built, and addressing is always unmirrored.

## Test plan
- Double buffer: write sprite 0 (x=100,y=50,w=47,h=41,base=0,en=1) without frame_start, drive col=100,row=50 -> spr_addr[0]=0 and pix_out=bg. After frame_start, same pixel -> spr_addr[0]=0 and pix_out=spr_data[0] at N+3.
- Addressing: sprite 0 as above, base=200, col=110,row=52 -> spr_addr[0]=200+2*47+10=304 at N+1. With COMPOSITOR_FLIP_EN and flip=1 -> 200+94+36=330.
- Priority and key: sprites 1 and 3 both hit, spr_data[1]=12'hF00, spr_data[3]=12'h0F0 -> pix_out=12'h0F0. With spr_data[3]=12'h428 -> pix_out=12'hF00. With both 12'h428 -> pix_out=bg_data.
- Clipping and zero size: sprite x=1000,w=47, col=1020 hits and col=5 does not. A sprite with w=0 never hits.
- Collision: sprites 2 and 5 opaque on the same pixel in frame k -> coll_flags=8'b0010_0100 after the next frame_start. With no overlap in frame k+1 -> coll_flags=0 after the following frame_start.
- Reset: assert rstn=0 mid-line with sprites active -> pix_out, pix_out_valid, spr_addr and coll_flags are 0 immediately, and sprites stay disabled after release.
